// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared score limits and the counter update action
package scoreboard_pkg;
   localparam int MAX_SCORE_DEFAULT = 99;
   localparam int SCORE_BW_DEFAULT  = 8;
   typedef enum logic [1:0] {ACT_NONE, ACT_INC, ACT_DEC, ACT_CLR} action_e;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronise, debounce and rising-edge detect one raw button
module button_debounce #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [1:0]    sync_q;
   logic          deb_q, deb_d, deb_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   // count consecutive disagreeing cycles; accept the new level on the last one
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = sync_q[1];
         else cnt_d = cnt_q + CW'(1);
      end
   end
   // synchroniser, debounce state and previous debounced level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], btn_i};
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
      end
   end
   assign press_o = deb_q & ~deb_prev_q;
endmodule

// File: rtl/score_counter.sv
// score_counter: saturating score driven by debounced inc/dec/clear buttons
module score_counter
   import scoreboard_pkg::*;
#(
   parameter int BW         = SCORE_BW_DEFAULT,
   parameter int MAX_SCORE  = MAX_SCORE_DEFAULT,
   parameter int DEB_CYCLES = 250000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          btn_inc_i,
   input  logic          btn_dec_i,
   input  logic          btn_clr_i,
   output logic [BW-1:0] score_o,
   output logic          at_min_o,
   output logic          at_max_o,
   output logic          changed_o
);
   logic          p_inc, p_dec, p_clr;
   action_e       act;
   logic [BW-1:0] score_q, score_d;
   logic          pend_q, changed_q;
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_inc_i), .press_o(p_inc));
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_dec_i), .press_o(p_dec));
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_clr_i), .press_o(p_clr));
   // clear wins, simultaneous inc+dec cancel, then saturating step
   always_comb begin
      act = p_clr ? ACT_CLR : (p_inc & p_dec) ? ACT_NONE : p_inc ? ACT_INC : p_dec ? ACT_DEC : ACT_NONE;
      score_d = (act == ACT_CLR) ? '0 :
                (act == ACT_INC && score_q != BW'(MAX_SCORE)) ? score_q + BW'(1) :
                (act == ACT_DEC && score_q != '0) ? score_q - BW'(1) : score_q;
   end
   // score register and change pulse delayed to the cycle after the update
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         score_q   <= '0;
         pend_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         score_q   <= score_d;
         pend_q    <= score_d != score_q;
         changed_q <= pend_q;
      end
   end
   assign score_o   = score_q;
   assign changed_o = changed_q;
   assign at_min_o  = score_q == '0;
   assign at_max_o  = score_q == BW'(MAX_SCORE);
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed vector and sequence checks for score_counter
module tb_score_counter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inc = 1'b0, dec = 1'b0, clr = 1'b0;
   logic [7:0] score;
   logic       at_min, at_max, changed;
   int         total_cnt = 0, pass_cnt = 0, pulses;

   typedef struct {
      logic inc, dec, clr;
      int   exp_score;
      logic exp_min, exp_max;
      int   exp_pulses;
   } vec_t;
   vec_t tbl[10];

   score_counter #(.BW(8), .MAX_SCORE(99), .DEB_CYCLES(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .btn_inc_i(inc), .btn_dec_i(dec), .btn_clr_i(clr),
      .score_o(score), .at_min_o(at_min), .at_max_o(at_max), .changed_o(changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (changed) pulses++;
   endtask

   task automatic press(input logic i, input logic d, input logic c);
      pulses = 0;
      inc = i; dec = d; clr = c;
      repeat (10) tick();
      inc = 0; dec = 0; clr = 0;
      repeat (10) tick();
   endtask

   task automatic do_reset();
      rst_n = 0;
      #3;
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1};
      tbl[9] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1};

      #2;
      chk("reset_score", score, 0);
      chk("reset_min", at_min, 1);
      chk("reset_max", at_max, 0);
      chk("reset_changed", changed, 0);
      do_reset();

      // exact latency of a clean press, held 10 cycles
      pulses = 0;
      inc = 1;
      repeat (6) tick();
      chk("lat_before", score, 0);
      tick();
      chk("lat_update", score, 1);
      chk("lat_chg_early", changed, 0);
      tick();
      chk("lat_chg_pulse", changed, 1);
      repeat (2) tick();
      inc = 0;
      repeat (12) tick();
      chk("hold_score", score, 1);
      chk("hold_pulses", pulses, 1);

      // short glitches never debounce
      do_reset();
      pulses = 0;
      inc = 1; repeat (3) tick();
      inc = 0; repeat (2) tick();
      inc = 1; repeat (3) tick();
      inc = 0; repeat (12) tick();
      chk("glitch_score", score, 0);
      chk("glitch_pulses", pulses, 0);

      // table-driven presses from zero
      do_reset();
      foreach (tbl[k]) begin
         press(tbl[k].inc, tbl[k].dec, tbl[k].clr);
         chk($sformatf("vec%0d_score", k), score, tbl[k].exp_score);
         chk($sformatf("vec%0d_min", k), at_min, tbl[k].exp_min);
         chk($sformatf("vec%0d_max", k), at_max, tbl[k].exp_max);
         chk($sformatf("vec%0d_pulses", k), pulses, tbl[k].exp_pulses);
      end

      // saturation at the top
      do_reset();
      for (int n = 0; n < 99; n++) press(1, 0, 0);
      chk("sat_score", score, 99);
      chk("sat_max", at_max, 1);
      chk("sat_last_pulse", pulses, 1);
      press(1, 0, 0);
      chk("sat100_score", score, 99);
      chk("sat100_pulses", pulses, 0);

      // inc+dec cancel at 42, then with clear
      do_reset();
      for (int n = 0; n < 42; n++) press(1, 0, 0);
      chk("s42_score", score, 42);
      press(1, 1, 0);
      chk("cancel_score", score, 42);
      chk("cancel_pulses", pulses, 0);
      press(1, 1, 1);
      chk("clr3_score", score, 0);
      chk("clr3_pulses", pulses, 1);
      chk("clr3_min", at_min, 1);

      // asynchronous reset mid-debounce with the button held
      do_reset();
      for (int n = 0; n < 57; n++) press(1, 0, 0);
      chk("s57_score", score, 57);
      inc = 1;
      repeat (4) tick();
      #2 rst_n = 0;
      #1;
      chk("arst_score", score, 0);
      chk("arst_min", at_min, 1);
      chk("arst_max", at_max, 0);
      chk("arst_changed", changed, 0);
      tick();
      rst_n = 1;
      repeat (6) tick();
      chk("rel_before", score, 0);
      tick();
      chk("rel_update", score, 1);
      inc = 0;
      repeat (10) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
